grf_write_arbiter: RTL

//  Writer-side front end of the GRF write port: produces the register-file write strobe, address, data and PC+4.

---
 rtl/grf_wb_pkg.sv | 25 ++
 rtl/grf_wb_queue.sv | 74 +++++++
 rtl/grf_write_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/grf_wb_pkg.sv
// Shared types for the GRF write arbiter and its MDU result queue.
// Entry layout: live flag, destination register, result and PC+4.
package grf_wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc4;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(
    input logic [REG_W-1:0] a
  );
    logic [31:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/grf_wb_queue.sv
// DEPTH-entry circular buffer of MDU results.
// Entries hit by a newer WB write to the same register are killed in place.
import grf_wb_pkg::*;

module grf_wb_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill,
  input  logic [REG_W-1:0] kill_addr,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      pend_mask
);

  wb_entry_t        q [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  assign head  = q[head_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q[i].addr == kill_addr) begin
            q[i].live <= 1'b0;
          end
        end
      end
      if (pop) begin
        q[head_ptr].live <= 1'b0;
        head_ptr         <= head_ptr + PTR_W'(1);
      end
      // a same-cycle push is newer than the killing WB write
      if (push) begin
        q[tail_ptr] <= push_entry;
        tail_ptr    <= tail_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].live) begin
        pend_mask = pend_mask | reg_onehot(q[i].addr);
      end
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// GRF write port front end: WB stage wins, queued MDU results fill idle cycles.
// Optional WB_TRACE_EN prints the GRF trace line for each registered write.
import grf_wb_pkg::*;

module grf_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_we,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  input  logic [31:0]            wb_pc4,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [4:0]             mdu_addr,
  input  logic [31:0]            mdu_data,
  input  logic [31:0]            mdu_pc4,
  output logic                   grf_we,
  output logic [4:0]             grf_addr,
  output logic [31:0]            grf_data,
  output logic [31:0]            grf_pc4,
  output logic [31:0]            pend_mask,
  output logic [$clog2(DEPTH):0] q_count
);

  logic      ready_en;
  logic      wb_issue;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;
  wb_entry_t push_entry;
  wb_entry_t head;

  assign wb_issue  = wb_we && (wb_addr != REG_ZERO);
  assign mdu_ready = ready_en && !full;
  // writes to $0 are acknowledged but never enter the queue
  assign push      = mdu_valid && mdu_ready && (mdu_addr != REG_ZERO);
  assign pop       = !wb_issue && !empty;

  assign push_entry = '{
    live: 1'b1,
    addr: mdu_addr,
    data: mdu_data,
    pc4:  mdu_pc4
  };

  grf_wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (wb_issue),
    .kill_addr  (wb_addr),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (q_count),
    .pend_mask  (pend_mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we   <= 1'b0;
      grf_addr <= '0;
      grf_data <= '0;
      grf_pc4  <= '0;
    end else begin
      unique case (1'b1)
        wb_issue: begin
          grf_we   <= 1'b1;
          grf_addr <= wb_addr;
          grf_data <= wb_data;
          grf_pc4  <= wb_pc4;
        end
        pop: begin
          grf_we <= head.live;
          if (head.live) begin
            grf_addr <= head.addr;
            grf_data <= head.data;
            grf_pc4  <= head.pc4;
          end
        end
        default: grf_we <= 1'b0;
      endcase
    end
  end

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (grf_we) begin
      $display("%d@%h: $%d <= %h", $time, grf_pc4 - 32'd4,
               grf_addr, grf_data);
    end
  end
`else
`endif

endmodule
